// File: rtl/deconv_frame_sched_pkg.sv
// Shared types and helpers for the deconvolution frame admission scheduler.
package deconv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } sched_state_t;

  localparam int unsigned INFLIGHT_W = 4;

  // Bits needed to hold a watchdog count of timeout_cycles.
  function automatic int unsigned wdt_width(input int unsigned timeout_cycles);
    return $clog2(64'(timeout_cycles) + 64'd1);
  endfunction

endpackage

// File: rtl/deconv_frame_sched_if.sv
// Upstream stream, chain-facing stream, chain feedback and status of the scheduler.
interface deconv_frame_sched_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                                   enable_i;
  logic                                   clr_i;
  logic [DATA_WIDTH-1:0]                  data_i;
  logic                                   data_valid_i;
  logic                                   sof_i;
  logic                                   eof_i;
  logic                                   sop_i;
  logic                                   eop_i;
  logic [DATA_WIDTH-1:0]                  data_o;
  logic                                   data_valid_o;
  logic                                   sof_o;
  logic                                   eof_o;
  logic                                   sop_o;
  logic                                   eop_o;
  logic                                   pipe_valid_i;
  logic                                   pipe_eof_i;
  logic [deconv_sched_pkg::INFLIGHT_W-1:0] inflight_o;
  logic                                   busy_o;
  logic [CNT_WIDTH-1:0]                   admit_cnt_o;
  logic [CNT_WIDTH-1:0]                   drop_cnt_o;
  logic                                   err_o;
  logic                                   timeout_o;

  modport master (
    output enable_i, clr_i, data_i, data_valid_i, sof_i, eof_i, sop_i, eop_i,
    output pipe_valid_i, pipe_eof_i,
    input  data_o, data_valid_o, sof_o, eof_o, sop_o, eop_o,
    input  inflight_o, busy_o, admit_cnt_o, drop_cnt_o, err_o, timeout_o
  );

  modport slave (
    input  enable_i, clr_i, data_i, data_valid_i, sof_i, eof_i, sop_i, eop_i,
    input  pipe_valid_i, pipe_eof_i,
    output data_o, data_valid_o, sof_o, eof_o, sop_o, eop_o,
    output inflight_o, busy_o, admit_cnt_o, drop_cnt_o, err_o, timeout_o
  );
endinterface

// File: rtl/deconv_frame_sched_credit_counter.sv
// Frames-in-flight credit counter: bounded up/down count with force-zero and underflow flag.
module credit_counter
  import deconv_sched_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_inc,
  input  logic                  i_dec,
  input  logic                  i_force_zero,
  output logic [INFLIGHT_W-1:0] o_count,
  output logic                  o_nonzero,
  output logic                  o_underflow_c
);

  logic [INFLIGHT_W-1:0] r_count;
  logic                  r_nonzero;
  logic [INFLIGHT_W-1:0] w_count_nxt;
  logic                  w_inc_ok;
  logic                  w_dec_ok;

  // A return against an empty count is an error and leaves the count alone.
  always_comb begin
    w_inc_ok    = i_inc && (r_count < INFLIGHT_W'(MAX_COUNT));
    w_dec_ok    = i_dec && (r_count != '0);
    w_count_nxt = r_count;
    if (i_force_zero) begin
      w_count_nxt = '0;
    end else if (w_inc_ok && !w_dec_ok) begin
      w_count_nxt = r_count + INFLIGHT_W'(1);
    end else if (w_dec_ok && !w_inc_ok) begin
      w_count_nxt = r_count - INFLIGHT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_nonzero <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_nonzero <= (w_count_nxt != '0);
    end
  end

  assign o_count       = r_count;
  assign o_nonzero     = r_nonzero;
  assign o_underflow_c = i_dec && (r_count == '0);

endmodule

// File: rtl/deconv_frame_sched.sv
// Whole-frame admission scheduler in front of a chain without backpressure;
// drops rejected frames whole, returns credits from the chain output, watchdog recovery.
module deconv_frame_sched
  import deconv_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_INFLIGHT   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  deconv_frame_sched_if.slave bus
);

  localparam int unsigned WDT_RAW  = wdt_width(TIMEOUT_CYCLES);
  localparam int unsigned WDT_W    = (WDT_RAW == 0) ? 1 : WDT_RAW;
  localparam int unsigned WDT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic        WDT_EN   = (TIMEOUT_CYCLES != 0);

  sched_state_t          r_state, w_state_nxt;
  logic                  w_fwd, w_admit, w_drop, w_frame_err;
  logic                  w_ret, w_fire, w_underflow, w_nonzero;
  logic [INFLIGHT_W-1:0] w_inflight;
  logic [WDT_W-1:0]      r_wdt;
  logic [DATA_WIDTH-1:0] r_data_o;
  logic                  r_valid_o, r_sof_o, r_eof_o, r_sop_o, r_eop_o;
  logic [CNT_WIDTH-1:0]  r_admit_cnt, r_drop_cnt;
  logic                  r_err, r_timeout;

  assign w_ret = bus.pipe_valid_i && bus.pipe_eof_i;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Admission is decided from the registered credit count, so a same-cycle return does not help.
  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_admit     = 1'b0;
    w_drop      = 1'b0;
    w_frame_err = 1'b0;
    if (bus.data_valid_i) begin
      case (r_state)
        IDLE: begin
          if (bus.sof_i) begin
            if (bus.enable_i && (w_inflight < INFLIGHT_W'(MAX_INFLIGHT))) begin
              w_fwd       = 1'b1;
              w_admit     = 1'b1;
              w_state_nxt = bus.eof_i ? IDLE : PASS;
            end else begin
              w_drop      = 1'b1;
              w_state_nxt = bus.eof_i ? IDLE : DROP;
            end
          end else begin
            w_frame_err = 1'b1;
          end
        end
        PASS: begin
          w_fwd       = 1'b1;
          w_frame_err = bus.sof_i;
          if (bus.eof_i) w_state_nxt = IDLE;
        end
        DROP: begin
          if (bus.eof_i) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  credit_counter #(.MAX_COUNT(MAX_INFLIGHT)) u_credit (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_inc        (w_admit),
    .i_dec        (w_ret),
    .i_force_zero (w_fire),
    .o_count      (w_inflight),
    .o_nonzero    (w_nonzero),
    .o_underflow_c(w_underflow)
  );

  // Watchdog: counts idle chain-output cycles while frames are in flight.
  assign w_fire = WDT_EN && (w_inflight != '0) && !bus.pipe_valid_i &&
                  (r_wdt == WDT_W'(WDT_LAST));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wdt <= '0;
    end else if (bus.pipe_valid_i || (w_inflight == '0) || w_fire) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + WDT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
      r_sof_o   <= 1'b0;
      r_eof_o   <= 1'b0;
      r_sop_o   <= 1'b0;
      r_eop_o   <= 1'b0;
    end else begin
      r_valid_o <= w_fwd;
      r_sof_o   <= w_fwd && bus.sof_i;
      r_eof_o   <= w_fwd && bus.eof_i;
      r_sop_o   <= w_fwd && bus.sop_i;
      r_eop_o   <= w_fwd && bus.eop_i;
      if (w_fwd) r_data_o <= bus.data_i;
    end
  end

  // Clear wins over any same-cycle set or increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_admit_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (bus.clr_i) begin
      r_admit_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_admit && (r_admit_cnt != '1)) r_admit_cnt <= r_admit_cnt + CNT_WIDTH'(1);
      if (w_drop && (r_drop_cnt != '1))   r_drop_cnt  <= r_drop_cnt + CNT_WIDTH'(1);
      if (w_frame_err || w_underflow)     r_err       <= 1'b1;
      if (w_fire)                         r_timeout   <= 1'b1;
    end
  end

  assign bus.data_o       = r_data_o;
  assign bus.data_valid_o = r_valid_o;
  assign bus.sof_o        = r_sof_o;
  assign bus.eof_o        = r_eof_o;
  assign bus.sop_o        = r_sop_o;
  assign bus.eop_o        = r_eop_o;
  assign bus.inflight_o   = w_inflight;
  assign bus.busy_o       = w_nonzero;
  assign bus.admit_cnt_o  = r_admit_cnt;
  assign bus.drop_cnt_o   = r_drop_cnt;
  assign bus.err_o        = r_err;
  assign bus.timeout_o    = r_timeout;

endmodule
